// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state type, width helper and constants for the TDC fine-code averager
package tdc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int OVR_W = 8;
  function automatic int acc_width(input int code_w, input int log2_avg);
    return code_w + log2_avg;
  endfunction
endpackage

// File: rtl/tdc_fine_averager_if.sv
// tdc_fine_averager_if: sample input, result output and handshake bundle of the fine-code averager
interface tdc_fine_averager_if import tdc_pkg::*; #(
  parameter int CODE_W = 5,
  parameter int ACC_W  = 9
);
  logic              start;
  logic [CODE_W-1:0] code_in;
  logic              code_vld;
  logic              busy;
  logic [ACC_W-1:0]  sum_out;
  logic [CODE_W-1:0] mean_out;
  logic [CODE_W-1:0] min_out;
  logic [CODE_W-1:0] max_out;
  logic              out_vld;
  logic              out_rdy;
  logic [OVR_W-1:0]  ovr_cnt;
  modport master (output start, code_in, code_vld, out_rdy,
                  input busy, sum_out, mean_out, min_out, max_out, out_vld, ovr_cnt);
  modport slave  (input start, code_in, code_vld, out_rdy,
                  output busy, sum_out, mean_out, min_out, max_out, out_vld, ovr_cnt);
endinterface

// File: rtl/tdc_minmax_tracker.sv
// tdc_minmax_tracker: running min/max registers with clear and update enables; exposes next values
module tdc_minmax_tracker #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         upd,
  input  logic [W-1:0] val,
  output logic [W-1:0] min_d,
  output logic [W-1:0] max_d
);
  logic [W-1:0] min_q, max_q;
  // next min/max: clear wins over update
  always_comb begin
    min_d = clr ? '1 : (upd && val < min_q) ? val : min_q;
    max_d = clr ? '0 : (upd && val > max_q) ? val : max_q;
  end
  // tracker registers
  always_ff @(posedge clk) begin
    min_q <= rst ? '1 : min_d;
    max_q <= rst ? '0 : max_d;
  end
endmodule

// File: rtl/tdc_fine_averager.sv
// tdc_fine_averager: accumulates 2^LOG2_AVG fine codes, reports sum/rounded mean/min/max; TDC_AVG_OVERRANGE_EN discards codes above MAX_CODE
module tdc_fine_averager import tdc_pkg::*; #(
  parameter int CODE_W   = 5,
  parameter int LOG2_AVG = 4,
  parameter int MAX_CODE = 16,
  parameter int ACC_W    = acc_width(CODE_W, LOG2_AVG)
) (
  input logic                clk,
  input logic                rst,
  tdc_fine_averager_if.slave bus
);
  localparam int N = 1 << LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
`ifdef TDC_AVG_OVERRANGE_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_nx, sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]  mean_q, mean_d, min_q, min_d, max_q, max_d, trk_min, trk_max;
  logic [OVR_W-1:0]   ovr_q, ovr_d;
  logic               go, ovr, take, last;
  assign go     = state_q == IDLE && bus.start;
  assign ovr    = OVR_EN && state_q == ACCUM && bus.code_vld && int'(bus.code_in) > MAX_CODE;
  assign take   = state_q == ACCUM && bus.code_vld && !ovr;
  assign last   = take && cnt_q == CNT_W'(N - 1);
  assign acc_nx = acc_q + ACC_W'(bus.code_in);
  tdc_minmax_tracker #(.W(CODE_W)) u_trk (
    .clk   (clk),
    .rst   (rst),
    .clr   (go),
    .upd   (take),
    .val   (bus.code_in),
    .min_d (trk_min),
    .max_d (trk_max)
  );
  // FSM next state, accumulation and result capture on the edge taking the final sample
  always_comb begin
    state_d = go ? ACCUM : last ? DONE : (state_q == DONE && bus.out_rdy) ? IDLE : state_q;
    acc_d   = go ? '0 : take ? acc_nx : acc_q;
    cnt_d   = go ? '0 : take ? cnt_q + CNT_W'(1) : cnt_q;
    sum_d   = last ? acc_nx : sum_q;
    mean_d  = last ? CODE_W'((acc_nx + ACC_W'(N / 2)) >> LOG2_AVG) : mean_q;
    min_d   = last ? trk_min : min_q;
    max_d   = last ? trk_max : max_q;
    ovr_d   = go ? '0 : (ovr && ovr_q != '1) ? ovr_q + OVR_W'(1) : ovr_q;
  end
  // state and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      mean_q  <= '0;
      min_q   <= '0;
      max_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      mean_q  <= mean_d;
      min_q   <= min_d;
      max_q   <= max_d;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.busy     = state_q != IDLE;
  assign bus.out_vld  = state_q == DONE;
  assign bus.sum_out  = sum_q;
  assign bus.mean_out = mean_q;
  assign bus.min_out  = min_q;
  assign bus.max_out  = max_q;
  assign bus.ovr_cnt  = ovr_q;
endmodule

// File: tb/tb_tdc_fine_averager.sv
// tb_tdc_fine_averager: scoreboard bench for tdc_fine_averager (default parameters)
module tb_tdc_fine_averager;
  localparam int N = 16;
  localparam int MAXC = 16;
`ifdef TDC_AVG_OVERRANGE_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  typedef struct {int sum; int mean; int mn; int mx; int ov;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  res_t sb[$];
  res_t last_r;
  tdc_fine_averager_if #(.CODE_W(5), .ACC_W(9)) bus ();
  tdc_fine_averager dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic chk_res(input string tag, input res_t r);
    chk({tag, "_sum"}, 32'(bus.sum_out), r.sum);
    chk({tag, "_mean"}, 32'(bus.mean_out), r.mean);
    chk({tag, "_min"}, 32'(bus.min_out), r.mn);
    chk({tag, "_max"}, 32'(bus.max_out), r.mx);
    chk({tag, "_ovr"}, 32'(bus.ovr_cnt), r.ov);
  endtask
  task automatic burst(input int codes[$], input int gap);
    int acc = 0, cnt = 0, mn = 31, mx = 0, ov = 0;
    res_t r;
    bus.start = 1'b1;
    bus.code_in = 5'd31;
    bus.code_vld = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < codes.size() && cnt < N; i++) begin
      bus.code_in = 5'(codes[i]);
      bus.code_vld = 1'b1;
      if (OVR_EN && codes[i] > MAXC) ov = (ov == 255) ? 255 : ov + 1;
      else begin
        acc += codes[i];
        cnt++;
        mn = codes[i] < mn ? codes[i] : mn;
        mx = codes[i] > mx ? codes[i] : mx;
      end
      if (cnt == N) begin
        r = '{acc, (acc + N / 2) / N, mn, mx, ov};
        sb.push_back(r);
      end
      @(negedge clk);
      bus.code_vld = 1'b0;
      if (cnt < N) begin
        chk("busy", 32'(bus.busy), 1);
        chk("early", 32'(bus.out_vld), 0);
        repeat (gap) @(negedge clk);
      end
    end
    chk("lat", 32'(bus.out_vld), 1);
    if (sb.size() == 0) chk("sb_empty", 0, 1);
    else begin
      last_r = sb.pop_front();
      chk_res("res", last_r);
    end
  endtask
  task automatic drop_check();
    @(negedge clk);
    chk("drop_vld", 32'(bus.out_vld), 0);
    chk("drop_busy", 32'(bus.busy), 0);
    chk("retain_sum", 32'(bus.sum_out), last_r.sum);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int q[$];
    bus.start = 1'b0;
    bus.code_in = '0;
    bus.code_vld = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk_res("rst", '{0, 0, 0, 0, 0});
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_vld", 32'(bus.out_vld), 0);
    rst = 1'b0;
    @(negedge clk);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(10);
    burst(q, 0);
    drop_check();
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(3 + (i % 2));
    burst(q, 0);
    drop_check();
    q = {};
    for (int i = 0; i < 15; i++) q.push_back(0);
    q.push_back(16);
    burst(q, 1);
    drop_check();
    bus.out_rdy = 1'b0;
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(i);
    burst(q, 0);
    for (int k = 0; k < 5; k++) begin
      bus.start = (k == 2);
      @(negedge clk);
      chk("bp_vld", 32'(bus.out_vld), 1);
      chk_res("bp", last_r);
    end
    bus.start = 1'b0;
    bus.out_rdy = 1'b1;
    drop_check();
    @(negedge clk);
    chk("bp_idle", 32'(bus.busy), 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.code_in = 5'd9;
      bus.code_vld = 1'b1;
      @(negedge clk);
    end
    bus.code_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_vld", 32'(bus.out_vld), 0);
    chk("mid_rst_sum", 32'(bus.sum_out), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 0);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(2);
    burst(q, 0);
    drop_check();
    q = {};
    for (int i = 0; i < 16; i++) begin
      if (i == 3 || i == 8 || i == 12) q.push_back(31);
      q.push_back(5);
    end
    burst(q, 0);
    drop_check();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
